// File: rtl/sram_port_arbiter.sv
// sram_port_arbiter
//   Front end for a single-port SRAM shared by two requesters. After reset
//   (or a clr pulse) it sweeps every address writing zero, then arbitrates
//   the port round-robin between requester 0 and requester 1, one access
//   per cycle. Read data comes back one cycle after the grant, matching the
//   SRAM's registered-address read.
//
// Ports
//   clk, rst_n                  clock, asynchronous active-low reset
//   clr                         pulse: restart the clear sweep
//   req*/we*/addr*/wdata*       requester access (held until gnt*)
//   gnt*                        combinational grant, access issued this cycle
//   rvalid*/rdata*              read return, one cycle after a read grant
//   init_done                   high once the sweep has finished
//   sram_data/addr/we, sram_q   SRAM macro pins
module sram_port_arbiter #(
  parameter int DATA_WIDTH = 4,
  parameter int ADDR_WIDTH = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  clr,
  input  logic                  req0,
  input  logic                  req1,
  input  logic                  we0,
  input  logic                  we1,
  input  logic [ADDR_WIDTH-1:0] addr0,
  input  logic [ADDR_WIDTH-1:0] addr1,
  input  logic [DATA_WIDTH-1:0] wdata0,
  input  logic [DATA_WIDTH-1:0] wdata1,
  output logic                  gnt0,
  output logic                  gnt1,
  output logic                  rvalid0,
  output logic                  rvalid1,
  output logic [DATA_WIDTH-1:0] rdata0,
  output logic [DATA_WIDTH-1:0] rdata1,
  output logic                  init_done,
  output logic [DATA_WIDTH-1:0] sram_data,
  output logic [ADDR_WIDTH-1:0] sram_addr,
  output logic                  sram_we,
  input  logic [DATA_WIDTH-1:0] sram_q
);

  typedef enum logic {
    INIT,
    RUN
  } state_e;

  localparam logic [ADDR_WIDTH-1:0] CNT_LAST = '1;

  state_e                state_q, state_d;
  logic [ADDR_WIDTH-1:0] cnt_q, cnt_d;
  logic [ADDR_WIDTH-1:0] last_addr_q, last_addr_d;
  logic                  prio_q, prio_d;
  logic                  rvalid0_q, rvalid0_d;
  logic                  rvalid1_q, rvalid1_d;

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    last_addr_d = last_addr_q;
    prio_d      = prio_q;
    rvalid0_d   = 1'b0;
    rvalid1_d   = 1'b0;
    gnt0        = 1'b0;
    gnt1        = 1'b0;
    sram_we     = 1'b0;
    sram_addr   = last_addr_q;  // idle port keeps the last driven address
    sram_data   = '0;

    case (state_q)
      INIT: begin
        sram_we     = 1'b1;
        sram_addr   = cnt_q;
        last_addr_d = cnt_q;
        if (clr) begin
          cnt_d = '0;
        end else if (cnt_q == CNT_LAST) begin
          cnt_d   = '0;
          state_d = RUN;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end

      RUN: begin
        // prio names the requester that wins a tie
        gnt0 = req0 & (~req1 | ~prio_q);
        gnt1 = req1 & (~req0 |  prio_q);
        if (gnt0) begin
          sram_we     = we0;
          sram_addr   = addr0;
          sram_data   = wdata0;
          last_addr_d = addr0;
          prio_d      = 1'b1;
          rvalid0_d   = ~we0;
        end else if (gnt1) begin
          sram_we     = we1;
          sram_addr   = addr1;
          sram_data   = wdata1;
          last_addr_d = addr1;
          prio_d      = 1'b0;
          rvalid1_d   = ~we1;
        end
        // this cycle's grant still completes; the sweep starts next edge
        if (clr) begin
          state_d = INIT;
          cnt_d   = '0;
        end
      end

      default: state_d = INIT;
    endcase

    // reset forces the port quiet immediately, not just at the next edge
    if (!rst_n) begin
      gnt0    = 1'b0;
      gnt1    = 1'b0;
      sram_we = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= INIT;
      cnt_q       <= '0;
      last_addr_q <= '0;
      prio_q      <= 1'b0;
      rvalid0_q   <= 1'b0;
      rvalid1_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      last_addr_q <= last_addr_d;
      prio_q      <= prio_d;
      rvalid0_q   <= rvalid0_d;
      rvalid1_q   <= rvalid1_d;
    end
  end

  assign init_done = (state_q == RUN);
  assign rvalid0   = rvalid0_q;
  assign rvalid1   = rvalid1_q;
  assign rdata0    = sram_q;
  assign rdata1    = sram_q;

endmodule
